fp_div_issue: RTL and testbench

FP_DIV_ISSUE -- requirements
Module: fp_div_issue

---
 rtl/fp_div_issue_if.sv | 24 ++
 rtl/fp_div_issue.sv | 142 ++++++++++++++
 tb/tb_fp_div_issue.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/fp_div_issue_if.sv
// rtl/fp_div_issue_if.sv - operand, divider and result signals of the FP divide issue stage
interface fp_div_issue_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic [31:0] div_a;
   logic [31:0] div_b;
   logic [31:0] div_c;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_c;
   logic [3:0]  out_flags;

   modport slave (
      input  in_valid, in_a, in_b, div_c, out_ready,
      output in_ready, div_a, div_b, out_valid, out_c, out_flags
   );

   modport master (
      output in_valid, in_a, in_b, div_c, out_ready,
      input  in_ready, div_a, div_b, out_valid, out_c, out_flags
   );
endinterface

// File: rtl/fp_div_issue.sv
// rtl/fp_div_issue.sv - single-precision divide issue stage: special-case filter, divider hold, result hold
module fp_div_issue #(
   parameter int unsigned DIV_LAT = 8
) (
   input  logic          clk,
   input  logic          rst,
   fp_div_issue_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

   localparam logic [3:0]  CNT_LAST = 4'(DIV_LAT - 1);
   localparam logic [31:0] QNAN     = 32'h7FC00000;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] div_a_q, div_a_d;
   logic [31:0] div_b_q, div_b_d;
   logic [31:0] out_c_q, out_c_d;
   logic [3:0]  flags_q, flags_d;

   logic [7:0]  ea, eb;
   logic [22:0] ma, mb;
   logic        za, zb, ia, ib, na, nb, sgn;
   logic signed [9:0] exp_e;
   logic        special;
   logic [31:0] spec_c;
   logic [3:0]  spec_f;
   logic        accept, capture;

   assign ea  = bus.in_a[30:23];
   assign eb  = bus.in_b[30:23];
   assign ma  = bus.in_a[22:0];
   assign mb  = bus.in_b[22:0];
   assign sgn = bus.in_a[31] ^ bus.in_b[31];

   // Denormals have exponent 0 and are flushed to zero by the class test alone.
   assign za = (ea == 8'h00);
   assign zb = (eb == 8'h00);
   assign ia = (ea == 8'hFF) && (ma == 23'h0);
   assign ib = (eb == 8'hFF) && (mb == 23'h0);
   assign na = (ea == 8'hFF) && (ma != 23'h0);
   assign nb = (eb == 8'hFF) && (mb != 23'h0);

   always_comb begin
      exp_e   = $signed({2'b00, ea}) - $signed({2'b00, eb})
              + ((ma < mb) ? 10'sd126 : 10'sd127);
      special = 1'b1;
      spec_c  = {sgn, 31'h0};
      spec_f  = 4'b0000;
      if (na | nb) begin
         spec_c = QNAN;
         spec_f = 4'b1000;
      end else if ((za & zb) | (ia & ib)) begin
         spec_c = QNAN;
         spec_f = 4'b1000;
      end else if (ia) begin
         spec_c = {sgn, 8'hFF, 23'h0};
      end else if (zb) begin
         spec_c = {sgn, 8'hFF, 23'h0};
         spec_f = 4'b0100;
      end else if (za | ib) begin
         spec_c = {sgn, 31'h0};
      end else if (exp_e > 10'sd254) begin
         spec_c = {sgn, 8'hFF, 23'h0};
         spec_f = 4'b0010;
      end else if (exp_e < 10'sd1) begin
         spec_c = {sgn, 31'h0};
         spec_f = 4'b0001;
      end else begin
         special = 1'b0;
      end
   end

   assign accept  = bus.in_valid && (state_q == IDLE);
   assign capture = (state_q == ISSUE) && (cnt_q == CNT_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept)        state_d = special ? HOLD : ISSUE;
         ISSUE:   if (capture)       state_d = HOLD;
         HOLD:    if (bus.out_ready) state_d = IDLE;
         default:                    state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready  = (state_q == IDLE);
      bus.out_valid = (state_q == HOLD);
   end

   // Divider operands only move on a normal accept; div_c is looked at on the capture edge only.
   always_comb begin
      cnt_d   = cnt_q;
      div_a_d = div_a_q;
      div_b_d = div_b_q;
      out_c_d = out_c_q;
      flags_d = flags_q;
      if (accept) begin
         cnt_d = 4'd0;
         if (special) begin
            out_c_d = spec_c;
            flags_d = spec_f;
         end else begin
            div_a_d = bus.in_a;
            div_b_d = bus.in_b;
         end
      end else if (state_q == ISSUE) begin
         cnt_d = cnt_q + 4'd1;
         if (capture) begin
            out_c_d = bus.div_c;
            flags_d = 4'b0000;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q   <= 4'd0;
         div_a_q <= 32'h0;
         div_b_q <= 32'h0;
         out_c_q <= 32'h0;
         flags_q <= 4'b0000;
      end else begin
         cnt_q   <= cnt_d;
         div_a_q <= div_a_d;
         div_b_q <= div_b_d;
         out_c_q <= out_c_d;
         flags_q <= flags_d;
      end
   end

   assign bus.div_a     = div_a_q;
   assign bus.div_b     = div_b_q;
   assign bus.out_c     = out_c_q;
   assign bus.out_flags = flags_q;
endmodule

// File: tb/tb_fp_div_issue.sv
// tb/tb_fp_div_issue.sv - randomized self-checking bench for fp_div_issue against a behavioural model
module tb_fp_div_issue;
   localparam int DIV_LAT = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cmp_count  = 0;
   int   fail_count = 0;
   logic [31:0] exp_div_a = 32'h0;
   logic [31:0] exp_div_b = 32'h0;

   fp_div_issue_if bus ();

   fp_div_issue #(.DIV_LAT(DIV_LAT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   // Result model: {special, flags[3:0], result[31:0]}; q is what the divider hands back.
   function automatic logic [36:0] ref_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] q);
      int  ea = int'(a[30:23]);
      int  eb = int'(b[30:23]);
      bit  s  = a[31] ^ b[31];
      bit  a_nan  = (ea == 255) && (a[22:0] != 0);
      bit  b_nan  = (eb == 255) && (b[22:0] != 0);
      bit  a_inf  = (ea == 255) && (a[22:0] == 0);
      bit  b_inf  = (eb == 255) && (b[22:0] == 0);
      bit  a_zero = (ea == 0);
      bit  b_zero = (eb == 0);
      logic [31:0] inf_v  = {s, 8'hFF, 23'h0};
      logic [31:0] zero_v = {s, 31'h0};
      int  e;
      if (a_nan || b_nan)                      return {1'b1, 4'b1000, 32'h7FC00000};
      if ((a_zero && b_zero) || (a_inf && b_inf)) return {1'b1, 4'b1000, 32'h7FC00000};
      if (a_inf)                               return {1'b1, 4'b0000, inf_v};
      if (b_zero)                              return {1'b1, 4'b0100, inf_v};
      if (a_zero || b_inf)                     return {1'b1, 4'b0000, zero_v};
      e = ea - eb + 127;
      if (a[22:0] < b[22:0]) e = e - 1;
      if (e > 254)                             return {1'b1, 4'b0010, inf_v};
      if (e < 1)                               return {1'b1, 4'b0001, zero_v};
      return {1'b0, 4'b0000, q};
   endfunction

   function automatic logic [31:0] gen_operand();
      int r = $urandom_range(0, 9);
      logic [31:0] v = $urandom;
      if (r == 0)      v[30:23] = 8'h00;
      else if (r == 1) begin
         v[30:23] = 8'hFF;
         if ($urandom_range(0, 1) == 0) v[22:0] = 23'h0;
      end else         v[30:23] = 8'($urandom_range(1, 254));
      return v;
   endfunction

   // Drives one transaction; div_c carries garbage except in the cycle before the capture edge.
   task automatic drive_txn(input logic [31:0] a, input logic [31:0] b, input logic [31:0] q,
                            input int hold, input bit toggle,
                            output int lat, output logic [31:0] c, output logic [3:0] f,
                            output logic [31:0] da, output logic [31:0] db, output bit stable);
      logic [31:0] da0;
      int k;
      stable = 1'b1;
      lat = -1;
      c = 32'h0; f = 4'h0; da = 32'h0; db = 32'h0;
      k = 0;
      while (bus.in_ready !== 1'b1 && k < 50) begin
         @(posedge clk); #1;
         k++;
      end
      bus.in_a = a; bus.in_b = b; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      da0 = bus.div_a;
      for (k = 0; k < 40; k++) begin
         if (bus.out_valid === 1'b1) begin
            lat = k;
            break;
         end
         if (bus.div_a !== da0) stable = 1'b0;
         if (toggle) begin
            bus.in_a = $urandom;
            bus.in_b = $urandom;
         end
         bus.div_c = (k == DIV_LAT - 1) ? q : $urandom;
         @(posedge clk); #1;
      end
      if (lat < 0) return;
      c = bus.out_c; f = bus.out_flags; da = bus.div_a; db = bus.div_b;
      for (int i = 0; i < hold; i++) begin
         bus.in_valid = 1'b1;
         bus.in_a = $urandom;
         bus.div_c = $urandom;
         @(posedge clk); #1;
         if (bus.out_valid !== 1'b1 || bus.out_c !== c || bus.out_flags !== f ||
             bus.in_ready !== 1'b0 || bus.div_a !== da) stable = 1'b0;
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b0;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) stable = 1'b0;
   endtask

   task automatic test_reset();
      bus.in_valid = 1'b1; bus.in_a = 32'h40C00000; bus.in_b = 32'h40000000;
      bus.div_c = 32'h0; bus.out_ready = 1'b0;
      #1;
      repeat (2) @(posedge clk);
      #1;
      cmp_count++; if (bus.in_ready !== 1'b1) begin fail_count++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
      cmp_count++; if (bus.out_valid !== 1'b0) begin fail_count++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
      cmp_count++; if (bus.out_c !== 32'h0 || bus.out_flags !== 4'h0) begin fail_count++; $display("FAIL reset_out: got %h/%b want 0/0000", bus.out_c, bus.out_flags); end
      cmp_count++; if (bus.div_a !== 32'h0 || bus.div_b !== 32'h0) begin fail_count++; $display("FAIL reset_div: got %h/%h want 0/0", bus.div_a, bus.div_b); end
      bus.in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_normal();
      int lat; logic [31:0] c, da, db; logic [3:0] f; bit st;
      drive_txn(32'h40C00000, 32'h40000000, 32'h40400000, 0, 1'b0, lat, c, f, da, db, st);
      cmp_count++; if (lat !== DIV_LAT) begin fail_count++; $display("FAIL normal_latency: got cycle %0d want %0d", lat + 1, DIV_LAT + 1); end
      cmp_count++; if (c !== 32'h40400000 || f !== 4'b0000) begin fail_count++; $display("FAIL normal_result: got %h/%b want 40400000/0000", c, f); end
      cmp_count++; if (da !== 32'h40C00000 || db !== 32'h40000000) begin fail_count++; $display("FAIL normal_div_ops: got %h/%h want 40c00000/40000000", da, db); end
      cmp_count++; if (st !== 1'b1) begin fail_count++; $display("FAIL normal_handshake: got %b want 1", st); end
      exp_div_a = 32'h40C00000; exp_div_b = 32'h40000000;
   endtask

   task automatic test_specials();
      logic [31:0] va [10] = '{32'h3F800000, 32'h00000000, 32'hFF800000, 32'h7F000000, 32'h00800000,
                               32'h7F812345, 32'h7F800000, 32'h80000000, 32'h40A00000, 32'hFF800000};
      logic [31:0] vb [10] = '{32'h00000000, 32'h00000000, 32'h40000000, 32'h00800000, 32'h7F000000,
                               32'h3F800000, 32'hFF800000, 32'h40A00000, 32'hFF800000, 32'h00000000};
      logic [31:0] wc [10] = '{32'h7F800000, 32'h7FC00000, 32'hFF800000, 32'h7F800000, 32'h00000000,
                               32'h7FC00000, 32'h7FC00000, 32'h80000000, 32'h80000000, 32'hFF800000};
      logic [3:0]  wf [10] = '{4'b0100, 4'b1000, 4'b0000, 4'b0010, 4'b0001,
                               4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
      int lat; logic [31:0] c, da, db; logic [3:0] f; bit st;
      for (int i = 0; i < 10; i++) begin
         drive_txn(va[i], vb[i], $urandom, 0, 1'b0, lat, c, f, da, db, st);
         cmp_count++; if (lat !== 0) begin fail_count++; $display("FAIL special%0d_latency: got cycle %0d want 1", i, lat + 1); end
         cmp_count++; if (c !== wc[i] || f !== wf[i]) begin fail_count++; $display("FAIL special%0d_result: got %h/%b want %h/%b", i, c, f, wc[i], wf[i]); end
         cmp_count++; if (da !== exp_div_a || db !== exp_div_b) begin fail_count++; $display("FAIL special%0d_div_ops: got %h/%h want %h/%h", i, da, db, exp_div_a, exp_div_b); end
      end
   endtask

   task automatic test_exp_bounds();
      logic [31:0] va [4] = '{32'h7F000000, 32'h7F7FFFFF, 32'h00800000, 32'h40000000};
      logic [31:0] vb [4] = '{32'h3F000000, 32'h3F800000, 32'h3F800001, 32'h00800001};
      int lat; logic [31:0] c, da, db, q; logic [3:0] f; bit st; logic [36:0] m;
      for (int i = 0; i < 4; i++) begin
         q = $urandom;
         m = ref_model(va[i], vb[i], q);
         drive_txn(va[i], vb[i], q, 0, 1'b0, lat, c, f, da, db, st);
         cmp_count++; if (lat !== (m[36] ? 0 : DIV_LAT)) begin fail_count++; $display("FAIL bound%0d_latency: got %0d want %0d", i, lat, m[36] ? 0 : DIV_LAT); end
         cmp_count++; if (c !== m[31:0] || f !== m[35:32]) begin fail_count++; $display("FAIL bound%0d_result: got %h/%b want %h/%b", i, c, f, m[31:0], m[35:32]); end
         if (!m[36]) begin exp_div_a = va[i]; exp_div_b = vb[i]; end
      end
   endtask

   task automatic test_backpressure();
      int lat; logic [31:0] c, da, db; logic [3:0] f; bit st;
      drive_txn(32'h41200000, 32'h40A00000, 32'h40000000, 5, 1'b0, lat, c, f, da, db, st);
      cmp_count++; if (st !== 1'b1) begin fail_count++; $display("FAIL backpressure_normal_stable: got %b want 1", st); end
      cmp_count++; if (c !== 32'h40000000) begin fail_count++; $display("FAIL backpressure_normal_result: got %h want 40000000", c); end
      exp_div_a = 32'h41200000; exp_div_b = 32'h40A00000;
      drive_txn(32'h3F800000, 32'h00000000, $urandom, 5, 1'b0, lat, c, f, da, db, st);
      cmp_count++; if (st !== 1'b1 || c !== 32'h7F800000 || f !== 4'b0100) begin fail_count++; $display("FAIL backpressure_special: got stable=%b %h/%b want 1 7f800000/0100", st, c, f); end
   endtask

   task automatic test_stability();
      int lat; logic [31:0] c, da, db; logic [3:0] f; bit st;
      drive_txn(32'hC1100000, 32'h40400000, 32'hC0400000, 1, 1'b1, lat, c, f, da, db, st);
      cmp_count++; if (st !== 1'b1) begin fail_count++; $display("FAIL stability_div_a: got stable=%b want 1", st); end
      cmp_count++; if (da !== 32'hC1100000 || db !== 32'h40400000 || c !== 32'hC0400000) begin fail_count++; $display("FAIL stability_result: got %h/%h/%h want c1100000/40400000/c0400000", da, db, c); end
      exp_div_a = 32'hC1100000; exp_div_b = 32'h40400000;
   endtask

   task automatic test_random();
      int lat; logic [31:0] a, b, c, da, db, q; logic [3:0] f; bit st; logic [36:0] m;
      for (int i = 0; i < 30; i++) begin
         a = gen_operand(); b = gen_operand(); q = $urandom;
         m = ref_model(a, b, q);
         drive_txn(a, b, q, $urandom_range(0, 3), 1'($urandom_range(0, 1)), lat, c, f, da, db, st);
         if (!m[36]) begin exp_div_a = a; exp_div_b = b; end
         cmp_count++;
         if (lat !== (m[36] ? 0 : DIV_LAT) || c !== m[31:0] || f !== m[35:32] ||
             da !== exp_div_a || db !== exp_div_b || st !== 1'b1) begin
            fail_count++;
            $display("FAIL random%0d %h/%h: got lat=%0d %h/%b div=%h/%h st=%b want lat=%0d %h/%b div=%h/%h",
                     i, a, b, lat, c, f, da, db, st, m[36] ? 0 : DIV_LAT, m[31:0], m[35:32], exp_div_a, exp_div_b);
         end
      end
   endtask

   task automatic test_reset_mid_issue();
      int seen = 0;
      bus.in_a = 32'h40C00000; bus.in_b = 32'h40000000; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      cmp_count++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin fail_count++; $display("FAIL midreset_async: got in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid); end
      cmp_count++; if (bus.div_a !== 32'h0 || bus.div_b !== 32'h0 || bus.out_c !== 32'h0) begin fail_count++; $display("FAIL midreset_regs: got %h/%h/%h want 0/0/0", bus.div_a, bus.div_b, bus.out_c); end
      @(posedge clk); #2;
      rst = 1'b1;
      for (int i = 0; i < 20; i++) begin
         bus.div_c = $urandom;
         @(posedge clk); #1;
         if (bus.out_valid !== 1'b0) seen++;
      end
      cmp_count++; if (seen !== 0) begin fail_count++; $display("FAIL midreset_no_result: got %0d valid cycles want 0", seen); end
      exp_div_a = 32'h0; exp_div_b = 32'h0;
   endtask

   initial begin
      bus.in_valid = 1'b0; bus.in_a = 32'h0; bus.in_b = 32'h0;
      bus.div_c = 32'h0; bus.out_ready = 1'b0;
      test_reset();
      test_normal();
      test_specials();
      test_exp_bounds();
      test_backpressure();
      test_stability();
      test_random();
      test_reset_mid_issue();
      test_normal();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
      $finish;
   end
endmodule
